// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit: word-aligned handshaked memory requests, byte lanes, load extension.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned and illegal-funct3 accesses without touching memory.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [7:0] TO   = 8'(TIMEOUT);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  logic        w_access;
  logic        w_reject;
  logic        w_timeout;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign w_access  = load_i | store_i;
  assign w_timeout = (r_cnt == TO);

  // Normalise funct3 to a size/unsigned pair; unknown encodings fall back to a full word.
  always_comb begin
    w_size = SZ_W;
    w_uns  = 1'b0;
    if (store_i) begin
      case (funct3_i)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (funct3_i)
        3'b000:  w_size = SZ_B;
        3'b100: begin w_size = SZ_B; w_uns = 1'b1; end
        3'b001:  w_size = SZ_H;
        3'b101: begin w_size = SZ_H; w_uns = 1'b1; end
        default: w_size = SZ_W;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_illegal;
  logic w_misalign;
  always_comb begin
    if (store_i) w_illegal = (funct3_i != 3'b000) && (funct3_i != 3'b001) && (funct3_i != 3'b010);
    else         w_illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    w_misalign = ((w_size == SZ_H) && addr_i[0]) || ((w_size == SZ_W) && (addr_i[1:0] != 2'b00));
    w_reject   = w_access && (w_illegal || w_misalign);
  end
`else
  assign w_reject = 1'b0;
`endif

  always_comb begin
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_access) w_next = w_reject ? S_DONE : S_REQ;
      S_REQ:  if (mem_ack_i || w_timeout) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = (r_state == S_REQ);
    stall_o   = ((r_state == S_IDLE) && w_access) || (r_state == S_REQ);
    err_o     = (r_state == S_DONE) && r_err;
  end

  // Request latch, wait counter and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_size  <= SZ_W;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_rdata <= 32'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && w_reject) begin
            r_err <= 1'b1;
          end else if (w_access) begin
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
            r_size  <= w_size;
            r_uns   <= w_uns;
            r_off   <= addr_i[1:0];
            r_we    <= store_i;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (!r_we) r_rdata <= load_extend(mem_rdata_i, r_size, r_uns, r_off);
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o     = r_rdata;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT = 3); expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_i = 1'b0; store_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'd0; wdata_i = 32'd0; mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
    #12;
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst_we",    {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, 32'd0);
    chk("rst_be",    {28'd0, mem_be_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // LB 0x103, ack in the first REQ cycle
    present(1'b1, 1'b0, 3'b000, 32'h103, 32'd0);
    chk("lb_stall0", {31'd0, stall_o}, 32'd1);
    chk("lb_req0",   {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); load_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h80FF_1234; #1;
    chk("lb_req1",   {31'd0, mem_req_o}, 32'd1);
    chk("lb_stall1", {31'd0, stall_o}, 32'd1);
    chk("lb_addr",   mem_addr_o, 32'h100);
    chk("lb_be",     {28'd0, mem_be_o}, 32'h8);
    chk("lb_we",     {31'd0, mem_we_o}, 32'd0);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("lb_stall2", {31'd0, stall_o}, 32'd0);
    chk("lb_rdata",  rdata_o, 32'hFFFF_FF80);
    chk("lb_err",    {31'd0, err_o}, 32'd0);

    // SH 0x22 issued in the first IDLE cycle after DONE
    present(1'b0, 1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF);
    chk("sh_stall0", {31'd0, stall_o}, 32'd1);
    @(negedge clk); store_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("sh_req",   {31'd0, mem_req_o}, 32'd1);
    chk("sh_we",    {31'd0, mem_we_o}, 32'd1);
    chk("sh_addr",  mem_addr_o, 32'h20);
    chk("sh_be",    {28'd0, mem_be_o}, 32'hC);
    chk("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("sh_rdata", rdata_o, 32'hFFFF_FF80);
    chk("sh_stall2", {31'd0, stall_o}, 32'd0);

    // SB 0x11
    present(1'b0, 1'b1, 3'b000, 32'h11, 32'h1234_56A5);
    @(negedge clk); store_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("sb_addr",  mem_addr_o, 32'h10);
    chk("sb_be",    {28'd0, mem_be_o}, 32'h2);
    chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("sb_rdata", rdata_o, 32'hFFFF_FF80);

    // LHU 0x6 with three wait states
    present(1'b1, 1'b0, 3'b101, 32'h6, 32'd0);
    chk("lhu_stall0", {31'd0, stall_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_i = 1'b0; #1;
      chk("lhu_wait_stall", {31'd0, stall_o}, 32'd1);
      chk("lhu_wait_req",   {31'd0, mem_req_o}, 32'd1);
    end
    @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 32'h8001_0000; #1;
    chk("lhu_stall4", {31'd0, stall_o}, 32'd1);
    chk("lhu_be",     {28'd0, mem_be_o}, 32'hC);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("lhu_stall5", {31'd0, stall_o}, 32'd0);
    chk("lhu_rdata",  rdata_o, 32'h0000_8001);

    // LW 0x102 (misaligned)
    present(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
    chk("lwm_stall0", {31'd0, stall_o}, 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk); load_i = 1'b0; #1;
    chk("lwm_req",    {31'd0, mem_req_o}, 32'd0);
    chk("lwm_stall1", {31'd0, stall_o}, 32'd0);
    chk("lwm_err",    {31'd0, err_o}, 32'd1);
    chk("lwm_rdata",  rdata_o, 32'h0000_8001);
    @(negedge clk); #1;
    chk("lwm_err_end", {31'd0, err_o}, 32'd0);
`else
    @(negedge clk); load_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
    chk("lwm_req",  {31'd0, mem_req_o}, 32'd1);
    chk("lwm_addr", mem_addr_o, 32'h100);
    chk("lwm_be",   {28'd0, mem_be_o}, 32'hF);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("lwm_rdata", rdata_o, 32'h1234_5678);
    chk("lwm_err",   {31'd0, err_o}, 32'd0);
`endif

    // LW 0x40, no ack: timeout after 4 request cycles
    present(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
    chk("to_req0", {31'd0, mem_req_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); load_i = 1'b0; #1;
      chk("to_req",   {31'd0, mem_req_o}, 32'd1);
      chk("to_noerr", {31'd0, err_o}, 32'd0);
    end
    @(negedge clk); #1;
    chk("to_req_end", {31'd0, mem_req_o}, 32'd0);
    chk("to_err",     {31'd0, err_o}, 32'd1);
    chk("to_rdata",   rdata_o, 32'd0);
    chk("to_stall",   {31'd0, stall_o}, 32'd0);
    @(negedge clk); #1;
    chk("to_err_once", {31'd0, err_o}, 32'd0);

    // Reset during REQ, late ack ignored, then SW
    present(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
    @(negedge clk); load_i = 1'b0; #1;
    chk("rq_req", {31'd0, mem_req_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rq_req_drop",   {31'd0, mem_req_o}, 32'd0);
    chk("rq_stall_drop", {31'd0, stall_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; #1;
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("rq_idle_req", {31'd0, mem_req_o}, 32'd0);
    chk("rq_idle_err", {31'd0, err_o}, 32'd0);
    chk("rq_rdata",    rdata_o, 32'd0);
    present(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D);
    chk("sw_stall0", {31'd0, stall_o}, 32'd1);
    @(negedge clk); store_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("sw_req",   {31'd0, mem_req_o}, 32'd1);
    chk("sw_we",    {31'd0, mem_we_o}, 32'd1);
    chk("sw_addr",  mem_addr_o, 32'h300);
    chk("sw_be",    {28'd0, mem_be_o}, 32'hF);
    chk("sw_wdata", mem_wdata_o, 32'hCAFE_F00D);
    @(negedge clk); mem_ack_i = 1'b0; #1;
    chk("sw_stall2", {31'd0, stall_o}, 32'd0);
    chk("sw_err",    {31'd0, err_o}, 32'd0);
    chk("sw_rdata",  rdata_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the MEM stage of the pipelined RV32I data path and a handshaked data memory. It converts a MEM-stage access (byte address, store data, funct3) into a word-aligned memory request with byte enables and a replicated write lane. It then returns sign- or zero-extended load data for write-back. While an access is outstanding it asserts a stall that freezes the PC and all pipeline registers.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles waiting for mem_ack_i before the access is aborted; range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- load_i  in  1  MEM-stage instruction is a load.
- store_i  in  1  MEM-stage instruction is a store; wins over load_i if both are high.
- funct3_i  in  3  access size and sign (RV32I encoding).
- addr_i  in  32  byte address (ALU result).
- wdata_i  in  32  store data (rs2 value).
- rdata_o  out  32  extended load data, registered.
- stall_o  out  1  hold the pipeline.
- err_o  out  1  one-cycle pulse for a misaligned, illegal or timed-out access.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address; bits [1:0] are always 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  memory read word.
- mem_ack_i  in  1  memory completes the request this cycle.

## Operation
FSM states: IDLE, REQ, DONE.
- **IDLE**
  - No access pending: stays in IDLE.
  - Valid access (load_i or store_i): latches address, be, wdata, we and funct3, then goes to REQ.
  - Rejected access (see Configuration): goes to DONE with the error flag set and no memory request.
- **REQ**
  - mem_req_o = 1; the latched request fields are held stable.
  - On mem_ack_i: goes to DONE. For a load, rdata_o is updated from mem_rdata_i.
  - If the 8-bit wait counter reaches TIMEOUT without an ack: goes to DONE, sets the error flag and clears rdata_o to 0.
- **DONE**
  - Returns to IDLE unconditionally.
  - Ignores load_i/store_i in this state, because the pipeline advances at the end of DONE.
- **stall_o** = (IDLE and (load_i or store_i)) or REQ. It is combinational and is low in DONE.
- **err_o** is high in DONE when the error flag is set; otherwise it is low.
- **Byte enables**
  - Byte access (funct3 000/100): 0001 << addr[1:0].
  - Halfword access (001/101): 0011 << {addr[1],1'b0}.
  - Word access (010): 1111.
- **Write data replication**
  - SB: {4{b}}.
  - SH: {2{h}}.
  - SW: word unchanged.
- **Load extraction**
  - The addressed byte or halfword is selected from mem_rdata_i using the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Illegal funct3**: 011, 110, 111 for loads; anything other than 000/001/010 for stores.

## Timing
- Reset values:
  - rdata_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_be_o = 0, mem_wdata_o = 0, err_o = 0.
  - State = IDLE, wait counter = 0.
- An access presented in cycle N gives mem_req_o high from N+1.
  - With ack in N+1, DONE is N+2: stall is high in N and N+1, and rdata_o is valid from N+2.
  - Minimum occupancy is 3 cycles per access.
- Each wait state adds one cycle.
- The wait counter clears on entry to REQ.
- The timeout fires on the cycle the counter equals TIMEOUT. With TIMEOUT = 3 and no ack, mem_req_o is high for 4 cycles.
- rdata_o holds its value until the next load completes or times out. Stores do not change rdata_o.
- Reset asserted mid-REQ clears mem_req_o and stall_o immediately (asynchronously). The request is abandoned, and any ack arriving after reset is ignored.
- Back-to-back accesses: the next access is accepted in the first IDLE cycle after DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - These accesses are rejected: halfword with addr[0] = 1, word with addr[1:0] ≠ 00, and illegal funct3.
  - A rejected access issues no memory request, holds stall for 1 cycle, pulses err_o in DONE and leaves rdata_o unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - The alignment check is not compiled in; illegal funct3 is executed as LW/SW.
  - Halfword accesses use addr[1] only; word accesses ignore addr[1:0].
  - err_o is raised only by timeout.

## Test plan
- LB, addr 0x103, memory word 0x80FF_1234 with ack after 1 cycle:
  - mem_addr_o = 0x100, mem_be_o = 1000, stall high for 2 cycles.
  - rdata_o = 0xFFFF_FF80.
- SH, addr 0x22, wdata 0xDEAD_BEEF:
  - mem_we_o = 1, mem_be_o = 1100, mem_wdata_o = 0xBEEF_BEEF, rdata_o unchanged.
- LHU, addr 0x6, word 0x8001_0000, ack delayed by 3 wait states:
  - stall held 5 cycles, rdata_o = 0x0000_8001.
- LW with TIMEOUT = 3 and no ack:
  - mem_req_o high for 4 cycles, err_o pulses once, rdata_o = 0.
- LW, addr 0x102:
  - With LSU_MISALIGN_TRAP_EN: no mem_req_o, err_o pulse, 1-cycle stall.
  - Without it: mem_addr_o = 0x100, normal completion.
- rst_n low during REQ:
  - mem_req_o and stall_o drop in the same cycle; after release the FSM is in IDLE and a following SW completes normally.
